// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame parser: parser states, frame header, bit-period math.
// The CSUM state exists only when UART_FRAME_CHECKSUM_EN is defined.
package uart_pkg;

  localparam logic [7:0] UART_FRAME_HDR = 8'hAA;

  // One UART character on the line is 10 bit times (start + 8 data + stop).
  localparam int BITS_PER_BYTE = 10;

`ifdef UART_FRAME_CHECKSUM_EN
  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CSUM    = 2'd3
  } parser_state_e;
`else
  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2
  } parser_state_e;
`endif

  // Clocks per bit period.
  function automatic int bps_cnt(input int clk_freq, input int uart_bps);
    return clk_freq / uart_bps;
  endfunction

  // Clocks of silence tolerated between two bytes of one frame.
  function automatic int gap_limit(input int clk_freq, input int uart_bps,
                                   input int timeout_bytes);
    return timeout_bytes * BITS_PER_BYTE * bps_cnt(clk_freq, uart_bps);
  endfunction

endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte gap timer. The count is the number of clocks since the last clear, so
// timeout fires in the cycle that is LIMIT-1 clocks after the clearing cycle.
module uart_gap_timer #(
  parameter int LIMIT = 400
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  // Clear loads 1 because the clock of the clearing cycle already counts as elapsed.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= W'(1);
    end else if (enable) begin
      if (cnt != W'(LIMIT)) cnt <= cnt + W'(1);
    end else begin
      cnt <= '0;
    end
  end

  assign timeout = enable && !clear && (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/uart_frame_parser.sv
// Frame parser: 0xAA, LEN, LEN payload bytes, optional checksum (UART_FRAME_CHECKSUM_EN).
// Payload bytes stream out before validation; consumers drop the frame on pkt_err.
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter int CLK_FREQ      = 50000000,
  parameter int UART_BPS      = 115200,
  parameter int MAX_LEN       = 64,
  parameter int TIMEOUT_BYTES = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       rec_busy,
  input  logic [7:0] rec_dout,
  output logic [7:0] pkt_data,
  output logic       pkt_valid,
  output logic [7:0] pkt_len,
  output logic       pkt_done,
  output logic       pkt_err,
  output logic       parser_busy
);

  localparam int         BPS_CNT   = bps_cnt(CLK_FREQ, UART_BPS);
  localparam int         GAP_LIMIT = TIMEOUT_BYTES * BITS_PER_BYTE * BPS_CNT;
  localparam logic [8:0] MAX_LEN_V = 9'(MAX_LEN);

  // Byte handshake: the receiver owns rec_busy; a byte is offered exactly once, in the
  // cycle where rec_busy was high last clock and is low now, and rec_dout is taken then.
  logic busy_q;
  logic strobe;

  parser_state_e state;
  parser_state_e state_nxt;

  logic [7:0] byte_cnt;
  logic       len_bad;
  logic       last_byte;
  logic       timeout;

  logic valid_d;
  logic done_d;
  logic err_d;
  logic len_load;
  logic data_load;

`ifdef UART_FRAME_CHECKSUM_EN
  logic [7:0] csum;
  logic       csum_ok;
  assign csum_ok = (rec_dout == csum);
`endif

  assign strobe    = busy_q && !rec_busy;
  assign len_bad   = (rec_dout == 8'd0) || ({1'b0, rec_dout} > MAX_LEN_V);
  assign last_byte = (byte_cnt == (pkt_len - 8'd1));

  uart_gap_timer #(
    .LIMIT (GAP_LIMIT)
  ) u_gap_timer (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clear     (strobe),
    .enable    (state != ST_HUNT),
    .timeout   (timeout)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= ST_HUNT;
    else            state <= state_nxt;
  end

  // A strobe always takes priority over a coincident timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_HUNT: begin
        if (strobe && (rec_dout == UART_FRAME_HDR)) state_nxt = ST_LEN;
      end
      ST_LEN: begin
        if (strobe)       state_nxt = len_bad ? ST_HUNT : ST_PAYLOAD;
        else if (timeout) state_nxt = ST_HUNT;
      end
      ST_PAYLOAD: begin
        if (strobe) begin
`ifdef UART_FRAME_CHECKSUM_EN
          if (last_byte) state_nxt = ST_CSUM;
`else
          if (last_byte) state_nxt = ST_HUNT;
`endif
        end else if (timeout) begin
          state_nxt = ST_HUNT;
        end
      end
`ifdef UART_FRAME_CHECKSUM_EN
      ST_CSUM: begin
        if (strobe || timeout) state_nxt = ST_HUNT;
      end
`endif
      default: state_nxt = ST_HUNT;
    endcase
  end

  always_comb begin
    valid_d   = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    len_load  = 1'b0;
    data_load = 1'b0;
    case (state)
      ST_LEN: begin
        if (strobe) begin
          err_d    = len_bad;
          len_load = !len_bad;
        end else begin
          err_d = timeout;
        end
      end
      ST_PAYLOAD: begin
        if (strobe) begin
          valid_d   = 1'b1;
          data_load = 1'b1;
`ifndef UART_FRAME_CHECKSUM_EN
          done_d    = last_byte;
`endif
        end else begin
          err_d = timeout;
        end
      end
`ifdef UART_FRAME_CHECKSUM_EN
      ST_CSUM: begin
        if (strobe) begin
          done_d = csum_ok;
          err_d  = !csum_ok;
        end else begin
          err_d = timeout;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      busy_q    <= 1'b0;
      pkt_valid <= 1'b0;
      pkt_done  <= 1'b0;
      pkt_err   <= 1'b0;
      pkt_data  <= 8'd0;
      pkt_len   <= 8'd0;
      byte_cnt  <= 8'd0;
    end else begin
      busy_q    <= rec_busy;
      pkt_valid <= valid_d;
      pkt_done  <= done_d;
      pkt_err   <= err_d;
      if (len_load) begin
        pkt_len  <= rec_dout;
        byte_cnt <= 8'd0;
      end
      if (data_load) begin
        pkt_data <= rec_dout;
        byte_cnt <= byte_cnt + 8'd1;
      end
    end
  end

`ifdef UART_FRAME_CHECKSUM_EN
  // Running sum seeds with LEN so the length byte is covered by the checksum.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)     csum <= 8'd0;
    else if (len_load)  csum <= rec_dout;
    else if (data_load) csum <= csum + rec_dout;
  end
`endif

  assign parser_busy = (state != ST_HUNT);

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser; expectations follow UART_FRAME_CHECKSUM_EN when defined.
module tb_uart_frame_parser;

  localparam int CLK_FREQ  = 1000000;
  localparam int UART_BPS  = 100000;
  localparam int MAX_LEN   = 64;
  localparam int TOUT      = 4;
  localparam int GAP_LIMIT = TOUT * 10 * (CLK_FREQ / UART_BPS);

  logic       sys_clk;
  logic       sys_rst_n;
  logic       rec_busy;
  logic [7:0] rec_dout;
  logic [7:0] pkt_data;
  logic       pkt_valid;
  logic [7:0] pkt_len;
  logic       pkt_done;
  logic       pkt_err;
  logic       parser_busy;

  int checks   = 0;
  int failures = 0;

  int cyc = 0;
  int last_strobe;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int last_valid_cyc = -1;
  int last_done_cyc = -1;
  int last_err_cyc = -1;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  uart_frame_parser #(
    .CLK_FREQ      (CLK_FREQ),
    .UART_BPS      (UART_BPS),
    .MAX_LEN       (MAX_LEN),
    .TIMEOUT_BYTES (TOUT)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .rec_busy    (rec_busy),
    .rec_dout    (rec_dout),
    .pkt_data    (pkt_data),
    .pkt_valid   (pkt_valid),
    .pkt_len     (pkt_len),
    .pkt_done    (pkt_done),
    .pkt_err     (pkt_err),
    .parser_busy (parser_busy)
  );

  // Clock and cycle count
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Output monitor, sampled mid-cycle
  always @(negedge sys_clk) begin
    if (pkt_valid) begin
      got_q.push_back(pkt_data);
      last_valid_cyc = cyc;
    end
    if (pkt_done) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
    if (pkt_err) begin
      err_cnt++;
      last_err_cyc = cyc;
    end
    if (pkt_done && pkt_err) both_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Driver: busy high for two clocks, then low; the low cycle is the strobe.
  task automatic send_byte(input logic [7:0] b);
    @(posedge sys_clk); #1;
    rec_busy = 1'b1;
    rec_dout = b;
    repeat (2) @(posedge sys_clk);
    #1;
    rec_busy = 1'b0;
    last_strobe = cyc;
    repeat (2) @(posedge sys_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic check_stream(input string name);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL %s: payload count %0d, required %0d", name, got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL %s[%0d]: pkt_data %h, required %h", name, i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    rec_busy  = 1'b0;
    rec_dout  = 8'h00;
    repeat (3) @(posedge sys_clk);
    #2;
    checks++;
    if ({pkt_data, pkt_len, pkt_valid, pkt_done, pkt_err, parser_busy} !== 20'h0) begin
      failures++;
      $display("FAIL reset_values: data=%h len=%h v=%b d=%b e=%b busy=%b, required all 0",
               pkt_data, pkt_len, pkt_valid, pkt_done, pkt_err, parser_busy);
    end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    idle(3);
  endtask

  task automatic test_good_frame();
    int d0, e0, s33;
    got_q.delete(); exp_q = '{8'h11, 8'h22, 8'h33};
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'hAA); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22);
    send_byte(8'h33); s33 = last_strobe;
    checks++;
    if (last_valid_cyc !== s33 + 1) begin
      failures++;
      $display("FAIL valid_latency: pulse cycle %0d, required %0d", last_valid_cyc, s33 + 1);
    end
    send_byte(8'h69);
    idle(3);
    check_stream("good_payload");
    checks++;
    if (pkt_len !== 8'h03) begin
      failures++;
      $display("FAIL good_len: pkt_len %h, required 03", pkt_len);
    end
    checks++;
    if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin
      failures++;
      $display("FAIL good_done: done %0d err %0d, required 1 and 0", done_cnt - d0, err_cnt - e0);
    end
`ifdef UART_FRAME_CHECKSUM_EN
    checks++;
    if (last_done_cyc !== last_strobe + 1) begin
      failures++;
      $display("FAIL done_latency: cycle %0d, required %0d", last_done_cyc, last_strobe + 1);
    end
`else
    checks++;
    if (last_done_cyc !== s33 + 1) begin
      failures++;
      $display("FAIL done_latency: cycle %0d, required %0d", last_done_cyc, s33 + 1);
    end
`endif
    checks++;
    if (pkt_data !== 8'h33 || parser_busy !== 1'b0) begin
      failures++;
      $display("FAIL good_hold: pkt_data %h busy %b, required 33 and 0", pkt_data, parser_busy);
    end
  endtask

  task automatic test_bad_csum();
    int d0, e0;
    got_q.delete(); exp_q = '{8'h10, 8'h20};
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'hAA); send_byte(8'h02); send_byte(8'h10); send_byte(8'h20);
    send_byte(8'h00);
    idle(3);
    check_stream("badcs_payload");
`ifdef UART_FRAME_CHECKSUM_EN
    checks++;
    if (done_cnt - d0 !== 0 || err_cnt - e0 !== 1) begin
      failures++;
      $display("FAIL badcs_err: done %0d err %0d, required 0 and 1", done_cnt - d0, err_cnt - e0);
    end
    checks++;
    if (last_err_cyc !== last_strobe + 1) begin
      failures++;
      $display("FAIL badcs_latency: cycle %0d, required %0d", last_err_cyc, last_strobe + 1);
    end
`else
    checks++;
    if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin
      failures++;
      $display("FAIL nocs_done: done %0d err %0d, required 1 and 0", done_cnt - d0, err_cnt - e0);
    end
`endif
  endtask

  task automatic test_bad_len();
    int e0, d0, s1, s2;
    got_q.delete();
    e0 = err_cnt; d0 = done_cnt;
    send_byte(8'h55); send_byte(8'h00);
    checks++;
    if (err_cnt !== e0 || parser_busy !== 1'b0) begin
      failures++;
      $display("FAIL noise: err delta %0d busy %b, required 0 and 0", err_cnt - e0, parser_busy);
    end
    send_byte(8'hAA); send_byte(8'h00); s1 = last_strobe;
    checks++;
    if (last_err_cyc !== s1 + 1) begin
      failures++;
      $display("FAIL len_zero: err cycle %0d, required %0d", last_err_cyc, s1 + 1);
    end
    send_byte(8'hAA); send_byte(8'h41); s2 = last_strobe;
    checks++;
    if (last_err_cyc !== s2 + 1) begin
      failures++;
      $display("FAIL len_over: err cycle %0d, required %0d", last_err_cyc, s2 + 1);
    end
    idle(2);
    checks++;
    if (err_cnt - e0 !== 2 || done_cnt !== d0 || got_q.size() !== 0 || pkt_len !== 8'h02) begin
      failures++;
      $display("FAIL bad_len_totals: err %0d done %0d valids %0d len %h, required 2 0 0 02",
               err_cnt - e0, done_cnt - d0, got_q.size(), pkt_len);
    end
  endtask

  task automatic test_timeout();
    int e0, s;
    e0 = err_cnt;
    send_byte(8'hAA); send_byte(8'h04); send_byte(8'h01); s = last_strobe;
    while (cyc < s + GAP_LIMIT + 5) begin
      @(posedge sys_clk); #1;
    end
    checks++;
    if (err_cnt - e0 !== 1 || last_err_cyc !== s + GAP_LIMIT) begin
      failures++;
      $display("FAIL timeout: errs %0d at cycle %0d, required 1 at %0d",
               err_cnt - e0, last_err_cyc, s + GAP_LIMIT);
    end
    checks++;
    if (parser_busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_hunt: parser_busy %b, required 0", parser_busy);
    end
  endtask

  task automatic test_timeout_tie();
    int e0, d0, s;
    got_q.delete(); exp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    e0 = err_cnt; d0 = done_cnt;
    send_byte(8'hAA); send_byte(8'h04); send_byte(8'h01); s = last_strobe;
    while (cyc < s + GAP_LIMIT - 2) begin
      @(posedge sys_clk); #1;
    end
    rec_busy = 1'b1; rec_dout = 8'h02;
    @(posedge sys_clk); #1;
    rec_busy = 1'b0;
    idle(5);
    checks++;
    if (err_cnt !== e0) begin
      failures++;
      $display("FAIL tie_strobe_wins: err delta %0d, required 0", err_cnt - e0);
    end
    send_byte(8'h03); send_byte(8'h04);
`ifdef UART_FRAME_CHECKSUM_EN
    send_byte(8'h0E);
`endif
    idle(3);
    check_stream("tie_payload");
    checks++;
    if (done_cnt - d0 !== 1 || err_cnt !== e0) begin
      failures++;
      $display("FAIL tie_done: done %0d err %0d, required 1 and 0", done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int d0, e0;
    send_byte(8'hAA); send_byte(8'h05); send_byte(8'h01); send_byte(8'h02);
    @(posedge sys_clk); #3;
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if ({pkt_data, pkt_len, pkt_valid, pkt_done, pkt_err, parser_busy} !== 20'h0) begin
      failures++;
      $display("FAIL midreset_async: data=%h len=%h v=%b d=%b e=%b busy=%b, required all 0",
               pkt_data, pkt_len, pkt_valid, pkt_done, pkt_err, parser_busy);
    end
    repeat (3) @(posedge sys_clk);
    #1;
    checks++;
    if ({pkt_data, pkt_len, pkt_valid, pkt_done, pkt_err, parser_busy} !== 20'h0) begin
      failures++;
      $display("FAIL midreset_hold: data=%h len=%h busy=%b, required all 0",
               pkt_data, pkt_len, parser_busy);
    end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    idle(3);
    got_q.delete(); exp_q = '{8'h7E};
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
    idle(3);
    check_stream("post_reset_payload");
    checks++;
    if (done_cnt - d0 !== 1 || err_cnt !== e0 || pkt_len !== 8'h01) begin
      failures++;
      $display("FAIL post_reset_frame: done %0d err %0d len %h, required 1 0 01",
               done_cnt - d0, err_cnt - e0, pkt_len);
    end
  endtask

  task automatic test_back_to_back();
    int d0, e0;
    got_q.delete(); exp_q.delete();
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'hAA); send_byte(8'h40);
    for (int i = 0; i < 64; i++) begin
      send_byte(8'hAA);
      exp_q.push_back(8'hAA);
    end
`ifdef UART_FRAME_CHECKSUM_EN
    send_byte(8'hC0);
`endif
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h55);
    exp_q.push_back(8'h55);
`ifdef UART_FRAME_CHECKSUM_EN
    send_byte(8'h56);
`endif
    idle(3);
    check_stream("b2b_payload");
    checks++;
    if (done_cnt - d0 !== 2 || err_cnt !== e0 || pkt_len !== 8'h01) begin
      failures++;
      $display("FAIL b2b_frames: done %0d err %0d len %h, required 2 0 01",
               done_cnt - d0, err_cnt - e0, pkt_len);
    end
    checks++;
    if (both_cnt !== 0) begin
      failures++;
      $display("FAIL done_err_exclusive: %0d overlapping cycles, required 0", both_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_bad_len();
    test_timeout();
    test_timeout_tie();
    test_reset_mid_frame();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
